// File: rtl/flipflop_ctrl_pkg.sv
// Shared definitions for the flipflop pulse sequencer.
//   state_t      : controller FSM states (IDLE / PULSE / GAP / RESP)
//   SEL_IN1/2    : encoding of cmd_sel (which flop input gets the pulse)
//   DEF_LEN_W/GAP: default field widths for pulse length and gap
`timescale 1ns/1ps
package flipflop_ctrl_pkg;

  localparam int DEF_LEN_W = 8;
  localparam int DEF_GAP_W = 8;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/flipflop_pulse_timer.sv
// Loadable down-counter used to time both the pulse and the gap phases.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : load load_val_i this edge (has priority over en_i)
//   en_i         : decrement this edge; saturates at zero, never wraps
//   load_val_i   : value to load (phase length minus one)
//   zero_o       : counter currently holds zero (last cycle of the phase)
`timescale 1ns/1ps
module flipflop_pulse_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/flipflop_pulse_ctrl.sv
// Pulse sequencer for one flipflop instance. Each accepted command drives
// ff_in1 or ff_in2 high for max(len,1) cycles, holds both low for gap cycles,
// then presents a one-cycle response describing what ff_out did.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready in IDLE and RESP)
//   cmd_sel/len/gap       : which input to pulse, pulse width, trailing gap
//   abort                 : cancel a command in PULSE or GAP
//   ff_in1/ff_in2         : registered drives into the flipflop
//   ff_out                : flipflop output
//   busy                  : high in PULSE or GAP
//   rsp_valid/out/seen    : completion pulse, ff_out at RESP entry, ff_out-ever-high
`timescale 1ns/1ps
module flipflop_pulse_ctrl
  import flipflop_ctrl_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic             ff_in1,
  output logic             ff_in2,
  input  logic             ff_out,
  output logic             busy,
  output logic             rsp_valid,
  output logic             rsp_out,
  output logic             rsp_seen
);

  localparam int CNT_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;

  state_t           state_q, state_d;
  logic             ff_in1_q, ff_in1_d;
  logic             ff_in2_q, ff_in2_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             seen_q, seen_d;
  logic             rsp_out_q, rsp_out_d;

  logic             tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             ready_state;
  logic             accept;

  assign ready_state = (state_q == ST_IDLE) || (state_q == ST_RESP);
  // accept needs no reset gating: every register is held in reset anyway.
  assign accept      = cmd_valid && ready_state;

  flipflop_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    ff_in1_d  = 1'b0;
    ff_in2_d  = 1'b0;
    gap_d     = gap_q;
    seen_d    = seen_q;
    rsp_out_d = rsp_out_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = '0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        // abort is ignored here; a command arriving in RESP starts with no bubble.
        state_d = ST_IDLE;
        if (accept) begin
          state_d  = ST_PULSE;
          gap_d    = cmd_gap;
          seen_d   = 1'b0;
          ff_in1_d = (cmd_sel == SEL_IN1);
          ff_in2_d = (cmd_sel == SEL_IN2);
          tmr_load = 1'b1;
          // len==0 is a one-cycle pulse, same as len==1.
          tmr_val  = (cmd_len == '0) ? '0 : (CNT_W'(cmd_len) - CNT_W'(1));
        end
      end

      ST_PULSE: begin
        ff_in1_d = ff_in1_q;
        ff_in2_d = ff_in2_q;
        if (ff_out) seen_d = 1'b1;
        if (abort) begin
          state_d  = ST_IDLE;
          ff_in1_d = 1'b0;
          ff_in2_d = 1'b0;
        end else if (tmr_zero) begin
          ff_in1_d = 1'b0;
          ff_in2_d = 1'b0;
          if (gap_q == '0) begin
            state_d   = ST_RESP;
            rsp_out_d = ff_out;
          end else begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(gap_q) - CNT_W'(1);
          end
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_GAP: begin
        if (ff_out) seen_d = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d   = ST_RESP;
          rsp_out_d = ff_out;
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ff_in1_q  <= 1'b0;
      ff_in2_q  <= 1'b0;
      gap_q     <= '0;
      seen_q    <= 1'b0;
      rsp_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ff_in1_q  <= ff_in1_d;
      ff_in2_q  <= ff_in2_d;
      gap_q     <= gap_d;
      seen_q    <= seen_d;
      rsp_out_q <= rsp_out_d;
    end
  end

  // Ready is forced low while reset is asserted so every output reads 0 in reset.
  assign cmd_ready = rst_n && ready_state;
  assign busy      = (state_q == ST_PULSE) || (state_q == ST_GAP);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_out   = rsp_out_q;
  assign rsp_seen  = seen_q;
  assign ff_in1    = ff_in1_q;
  assign ff_in2    = ff_in2_q;

endmodule

// File: tb/tb_flipflop_pulse_ctrl.sv
// Bench for flipflop_pulse_ctrl driving a set/reset flipflop model
// (in1 sets out, in2 clears out). Expected responses are queued at issue
// and popped by a monitor whenever rsp_valid is seen.
`timescale 1ns/1ps
module tb_flipflop_pulse_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_sel = 1'b0;
  logic [7:0] cmd_len = '0;
  logic [7:0] cmd_gap = '0;
  logic       abort = 1'b0;
  logic       ff_in1, ff_in2, ff_out;
  logic       busy, rsp_valid, rsp_out, rsp_seen;

  flipflop_pulse_ctrl #(.LEN_W(8), .GAP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .cmd_gap   (cmd_gap),
    .abort     (abort),
    .ff_in1    (ff_in1),
    .ff_in2    (ff_in2),
    .ff_out    (ff_out),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_out   (rsp_out),
    .rsp_seen  (rsp_seen)
  );

  always #25 clk = ~clk;

  // The flipflop under stimulus.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ff_out <= 1'b0;
    else if (ff_in1) ff_out <= 1'b1;
    else if (ff_in2) ff_out <= 1'b0;
  end

  typedef struct {
    logic sel;
    int   len;   // effective pulse length
    int   gap;
    logic out;
    logic seen;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  time  acc_time = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_cmd_ready"}, cmd_ready, 0);
    chk({pfx, "_busy"},      busy,      0);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_out"},   rsp_out,   0);
    chk({pfx, "_rsp_seen"},  rsp_seen,  0);
    chk({pfx, "_ff_in1"},    ff_in1,    0);
    chk({pfx, "_ff_in2"},    ff_in2,    0);
  endtask

  // Present a command, wait (bounded) for ready, push the expectation, and
  // release valid just after the accepting edge.
  task automatic issue(input logic sel, input int len, input int gap, input logic abt,
                       input bit push, input logic eout, input logic eseen);
    int   n;
    exp_t e;
    @(negedge clk);
    cmd_sel   = sel;
    cmd_len   = 8'(len);
    cmd_gap   = 8'(gap);
    abort     = abt;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("issue_ready_timeout", 0, 1);
    if (push) begin
      e.sel  = sel;
      e.len  = (len == 0) ? 1 : len;
      e.gap  = gap;
      e.out  = eout;
      e.seen = eseen;
      exp_q.push_back(e);
    end
    @(posedge clk);
    acc_time = $time;
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: counts per-command cycles and compares each response.
  bit   in_flight = 0;
  int   lat, c1, c2, rl;
  exp_t m_e;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (in_flight) begin
        lat++;
        if (ff_in1)     c1++;
        if (ff_in2)     c2++;
        if (!cmd_ready) rl++;
      end
      chk("in_exclusive", int'(ff_in1 && ff_in2), 0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          chk("rsp_out",    rsp_out,  m_e.out);
          chk("rsp_seen",   rsp_seen, m_e.seen);
          chk("rsp_latency", lat,     m_e.len + m_e.gap + 1);
          chk("sel_pulse_cycles",   (m_e.sel ? c2 : c1), m_e.len);
          chk("other_pulse_cycles", (m_e.sel ? c1 : c2), 0);
          chk("ready_low_cycles",   rl, m_e.len + m_e.gap);
        end
      end
      if (rst_n && cmd_valid && cmd_ready) begin
        in_flight = 1;
        lat = 0; c1 = 0; c2 = 0; rl = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  time t_a;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #19;
    check_all_zero("reset");
    #30 rst_n = 1'b1;            // released at 50 ns
    @(negedge clk); #1;
    chk("ready_after_reset", cmd_ready, 1);

    // sel, len, gap, abort, push, rsp_out, rsp_seen (flop model traced by hand)
    issue(1'b0,   1,   3, 1'b0, 1, 1'b1, 1'b1);   // 1: in1 1 cycle
    issue(1'b1,   4,   0, 1'b0, 1, 1'b0, 1'b1);   // 2: in2 4 cycles, no gap
    issue(1'b0,   0,   2, 1'b0, 1, 1'b1, 1'b1);   // 3a: len 0 acts as 1
    issue(1'b1, 255, 255, 1'b0, 1, 1'b0, 1'b1);   // 3b: max len/gap

    // 4: back-to-back, second command accepted in RESP of the first
    issue(1'b0, 2, 1, 1'b0, 1, 1'b1, 1'b1);
    t_a = acc_time;
    issue(1'b1, 3, 0, 1'b0, 1, 1'b0, 1'b1);
    chk("b2b_spacing_cycles", int'((acc_time - t_a) / 50), 4);
    @(negedge clk); #1;
    chk("b2b_in2_next_cycle", ff_in2, 1);

    issue(1'b0, 1, 0, 1'b0, 1, 1'b0, 1'b0);       // len 1 gap 0: out sampled pre-update
    drain();

    // 5: abort in cycle 2 of a len=5 pulse
    issue(1'b0, 5, 2, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_in1", ff_in1, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk); #1;
    chk("abort_in1", ff_in1, 0);
    chk("abort_in2", ff_in2, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);

    // abort held while accepting in IDLE is ignored
    issue(1'b1, 2, 1, 1'b1, 1, 1'b0, 1'b1);
    drain();

    // 6: reset mid-GAP
    issue(1'b0, 2, 10, 1'b0, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("gap_busy_before_reset", busy, 1);
    #5 rst_n = 1'b0;
    #1 check_all_zero("reset_gap");
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-PULSE drops ff_in immediately
    issue(1'b1, 6, 0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pulse_in2_before_reset", ff_in2, 1);
    #5 rst_n = 1'b0;
    #1 check_all_zero("reset_pulse");
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b1, 3, 2, 1'b0, 1, 1'b0, 1'b0);       // clean run after reset
    drain();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
